// File: rtl/sram_arb_pkg.sv
// ----------------------------------------------------------------------------
// sram_arb_pkg
// Shared types for the SRAM arbiter: the per-cycle slot encoding, the read
// client identifier and the tag that travels down the read-return pipe
// alongside each SRAM read so the data can be steered to its issuer.
// ----------------------------------------------------------------------------
package sram_arb_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_RD0  = 2'd1,
        SLOT_RD1  = 2'd2,
        SLOT_WR   = 2'd3
    } slot_e;

    typedef logic client_id_t;

    localparam client_id_t CLIENT_RD0 = 1'b0;
    localparam client_id_t CLIENT_RD1 = 1'b1;

    typedef struct packed {
        logic       vld;
        client_id_t id;
    } rd_tag_t;

    // Converts a slot decision into the tag that accompanies the SRAM access.
    function automatic rd_tag_t make_tag(input slot_e slot);
        rd_tag_t tag;
        case (slot)
            SLOT_RD0: begin
                tag.vld = 1'b1;
                tag.id  = CLIENT_RD0;
            end
            SLOT_RD1: begin
                tag.vld = 1'b1;
                tag.id  = CLIENT_RD1;
            end
            default: begin
                tag.vld = 1'b0;
                tag.id  = CLIENT_RD0;
            end
        endcase
        return tag;
    endfunction

endpackage

// File: rtl/sram_arb_wfifo.sv
// ----------------------------------------------------------------------------
// sram_arb_wfifo
// Synchronous FIFO holding pending {addr,data} writes for the SRAM arbiter.
// A push is taken only while not full (full is evaluated before any pop in the
// same cycle); a pop is taken only while not empty. Pointers wrap naturally
// because DEPTH is a power of two.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push_i      push request, data_i is the entry
//   pop_i       pop request, data_o shows the head entry (combinational)
//   full_o      DEPTH entries stored
//   empty_o     no entries stored
// ----------------------------------------------------------------------------
module sram_arb_wfifo #(
    parameter int W     = 38,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == CNT_FULL);
    assign empty_o   = (count_q == {(PTR_W + 1){1'b0}});
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign data_o    = mem_q[rptr_q];

    // Occupancy next-state from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok_s && pop_ok_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= {PTR_W{1'b0}};
            rptr_q  <= {PTR_W{1'b0}};
            count_q <= {(PTR_W + 1){1'b0}};
        end else begin
            wptr_q  <= push_ok_s ? (wptr_q + PTR_ONE) : wptr_q;
            rptr_q  <= pop_ok_s ? (rptr_q + PTR_ONE) : rptr_q;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// ----------------------------------------------------------------------------
// sram_arbiter
// Shares one single-port SRAM interface between two scan-out read clients
// (rd0 foreground, rd1 background) and one capture write client. One access
// (read or write) is issued per cycle. Writes are buffered in a FIFO and are
// forced out when the FIFO is full or has waited STARVE_LIMIT cycles, so the
// capture path never loses data while wr_ready is honoured.
// Each read carries a tag down a pipe matching the SRAM read latency so the
// returned word is routed to the client that issued it.
//
// Build option: define SRAM_ARB_RR_EN to arbitrate rd0/rd1 round-robin
// (last-granted reader loses a tie, rd0 favoured out of reset). Without it
// rd0 has fixed priority over rd1.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rdX_req/rdX_addr           read request, held with address until grant
//   rdX_grant                  combinational: request accepted this cycle
//   rdX_valid/rdX_data         1-cycle return pulse; data held until next pulse
//   wr_req/wr_addr/wr_data     write push, accepted only when wr_ready
//   wr_ready                   write FIFO not full
//   wr_overflow                sticky: push attempted while full
//   mem_re/mem_raddr           registered SRAM read strobe and address
//   mem_we/mem_waddr/mem_wdata registered SRAM write strobe, address, data
//   mem_rdata                  SRAM read data, valid RD_LATENCY cycles after mem_re
// ----------------------------------------------------------------------------
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 18,
    parameter int WFIFO_DEPTH  = 8,
    parameter int RD_LATENCY   = 3,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd0_req,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_grant,
    output logic              rd0_valid,
    output logic [DATA_W-1:0] rd0_data,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_grant,
    output logic              rd1_valid,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_overflow,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int FIFO_W   = ADDR_W + DATA_W;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

    slot_e               slot_d;
    slot_e               slot_q;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [FIFO_W-1:0]   fifo_dout_s;
    logic                wr_forced_s;
    logic [STARVE_W-1:0] starve_q;
    logic                overflow_q;
    logic                mem_re_q;
    logic [ADDR_W-1:0]   mem_raddr_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_waddr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   rd0_hold_q;
    logic [DATA_W-1:0]   rd1_hold_q;
    logic                rd0_valid_s;
    logic                rd1_valid_s;
    // slot_q is stage 0 of the return pipe; tag_q[k] is k cycles behind it.
    rd_tag_t             tag_q [1:RD_LATENCY];
`ifdef SRAM_ARB_RR_EN
    client_id_t          last_rd_q;
`endif

    sram_arb_wfifo #(
        .W     (FIFO_W),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (wr_req),
        .data_i  ({wr_addr, wr_data}),
        .pop_i   (slot_d == SLOT_WR),
        .data_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // A pending write pre-empts readers once the FIFO is full or has starved.
    assign wr_forced_s = !fifo_empty_s && (fifo_full_s || (starve_q == STARVE_MAX));

    // Slot decision for this cycle.
    always_comb begin
        slot_d = SLOT_IDLE;
        if (wr_forced_s) begin
            slot_d = SLOT_WR;
        end else if (rd0_req && rd1_req) begin
`ifdef SRAM_ARB_RR_EN
            slot_d = (last_rd_q == CLIENT_RD0) ? SLOT_RD1 : SLOT_RD0;
`else
            slot_d = SLOT_RD0;
`endif
        end else if (rd0_req) begin
            slot_d = SLOT_RD0;
        end else if (rd1_req) begin
            slot_d = SLOT_RD1;
        end else if (!fifo_empty_s) begin
            slot_d = SLOT_WR;
        end else begin
            slot_d = SLOT_IDLE;
        end
    end

    assign rd0_grant   = (slot_d == SLOT_RD0);
    assign rd1_grant   = (slot_d == SLOT_RD1);
    assign wr_ready    = !fifo_full_s;
    assign wr_overflow = overflow_q;

    assign mem_re    = mem_re_q;
    assign mem_raddr = mem_raddr_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;

    // The last tag stage lines up with the cycle mem_rdata carries that read.
    assign rd0_valid_s = tag_q[RD_LATENCY].vld && (tag_q[RD_LATENCY].id == CLIENT_RD0);
    assign rd1_valid_s = tag_q[RD_LATENCY].vld && (tag_q[RD_LATENCY].id == CLIENT_RD1);
    assign rd0_valid   = rd0_valid_s;
    assign rd1_valid   = rd1_valid_s;
    assign rd0_data    = rd0_valid_s ? mem_rdata : rd0_hold_q;
    assign rd1_data    = rd1_valid_s ? mem_rdata : rd1_hold_q;

    // Slot FSM with registered SRAM strobes, starvation counter, tag pipe,
    // sticky overflow and read-data hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= SLOT_IDLE;
            mem_re_q    <= 1'b0;
            mem_raddr_q <= {ADDR_W{1'b0}};
            mem_we_q    <= 1'b0;
            mem_waddr_q <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            starve_q    <= {STARVE_W{1'b0}};
            overflow_q  <= 1'b0;
            rd0_hold_q  <= {DATA_W{1'b0}};
            rd1_hold_q  <= {DATA_W{1'b0}};
            for (int k = 1; k <= RD_LATENCY; k++) begin
                tag_q[k] <= '{vld: 1'b0, id: CLIENT_RD0};
            end
`ifdef SRAM_ARB_RR_EN
            last_rd_q   <= CLIENT_RD1;
`endif
        end else begin
            slot_q   <= slot_d;
            mem_re_q <= (slot_d == SLOT_RD0) || (slot_d == SLOT_RD1);
            mem_we_q <= (slot_d == SLOT_WR);

            case (slot_d)
                SLOT_RD0: mem_raddr_q <= rd0_addr;
                SLOT_RD1: mem_raddr_q <= rd1_addr;
                default:  mem_raddr_q <= mem_raddr_q;
            endcase

            if (slot_d == SLOT_WR) begin
                mem_waddr_q <= fifo_dout_s[FIFO_W-1:DATA_W];
                mem_wdata_q <= fifo_dout_s[DATA_W-1:0];
            end else begin
                mem_waddr_q <= mem_waddr_q;
                mem_wdata_q <= mem_wdata_q;
            end

            if (fifo_empty_s || (slot_d == SLOT_WR)) begin
                starve_q <= {STARVE_W{1'b0}};
            end else if (starve_q != STARVE_MAX) begin
                starve_q <= starve_q + STARVE_ONE;
            end else begin
                starve_q <= starve_q;
            end

            overflow_q <= overflow_q || (wr_req && fifo_full_s);

            tag_q[1] <= make_tag(slot_q);
            for (int k = 2; k <= RD_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end

            rd0_hold_q <= rd0_valid_s ? mem_rdata : rd0_hold_q;
            rd1_hold_q <= rd1_valid_s ? mem_rdata : rd1_hold_q;

`ifdef SRAM_ARB_RR_EN
            case (slot_d)
                SLOT_RD0: last_rd_q <= CLIENT_RD0;
                SLOT_RD1: last_rd_q <= CLIENT_RD1;
                default:  last_rd_q <= last_rd_q;
            endcase
`endif
        end
    end

endmodule
